// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel synchronized, debounced edge detector with event pulse, sticky flag and filtered level
module edge_detect_multi #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE = 4,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  output logic [WIDTH-1:0]   o,
  output logic [WIDTH-1:0]   sticky,
  output logic [WIDTH-1:0]   level
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE - 1);
  logic [WIDTH-1:0] s_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_d [SYNC_STAGES];
  logic [CW-1:0] c_q [WIDTH];
  logic [CW-1:0] c_d [WIDTH];
  logic [WIDTH-1:0] f_q, f_d, o_q, o_d, sticky_q, sticky_d, acc, s_out;
  assign s_out = s_q[SYNC_STAGES-1];
  always_comb begin
    s_d[0] = i;
    for (int j = 1; j < SYNC_STAGES; j++) s_d[j] = s_q[j-1];
    acc = '0;
    f_d = f_q;
    o_d = '0;
    sticky_d = '0;
    for (int k = 0; k < WIDTH; k++) begin
      acc[k] = (s_out[k] != f_q[k]) && (c_q[k] == C_MAX);
      c_d[k] = (s_out[k] == f_q[k] || acc[k]) ? '0 : c_q[k] + 1'b1;
      f_d[k] = acc[k] ? s_out[k] : f_q[k];
      o_d[k] = acc[k] && (s_out[k] ? mode[2*k] : mode[2*k+1]);
      sticky_d[k] = (sticky_q[k] && !clr[k]) || o_d[k];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_STAGES; j++) s_q[j] <= {WIDTH{RESET_LEVEL}};
      for (int k = 0; k < WIDTH; k++) c_q[k] <= '0;
      f_q <= {WIDTH{RESET_LEVEL}};
      o_q <= '0;
      sticky_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      f_q <= f_d;
      o_q <= o_d;
      sticky_q <= sticky_d;
    end
  end
  assign o = o_q;
  assign sticky = sticky_q;
  assign level = f_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed and random checks of edge_detect_multi against a history-based reference model
module tb_edge_detect_multi;
  localparam int W = 4;
  localparam int SS = 2;
  localparam int DB = 3;
  localparam bit RL = 1'b0;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] i = '0;
  logic [W-1:0] clr = '0;
  logic [2*W-1:0] mode = '0;
  logic [W-1:0] o, sticky, level;
  int total = 0;
  int bad = 0;
  int n = 0;
  int last_rst = 0;
  int last_ev [W];
  int dut_p [W];
  int dut_pe [W];
  int dut_prev [W];
  logic [W-1:0] ih [0:8191];
  logic [W-1:0] mo = '0;
  logic [W-1:0] ms = '0;
  logic [W-1:0] mf = {W{RL}};
  edge_detect_multi #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DB), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .mode(mode), .clr(clr),
    .o(o), .sticky(sticky), .level(level)
  );
  always #5 clk = ~clk;
  function automatic logic sout(int e, int k);
    return (e - SS > last_rst) ? ih[e-SS][k] : RL;
  endfunction
  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask
  task automatic chkb(string tag, logic got, logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask
  task automatic chki(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask
  task automatic tick();
    n++;
    ih[n] = i;
    if (!rst_n) begin
      last_rst = n;
      mf = {W{RL}};
      mo = '0;
      ms = '0;
      for (int k = 0; k < W; k++) last_ev[k] = n;
    end else begin
      for (int k = 0; k < W; k++) begin
        logic acc;
        acc = (n - DB >= last_ev[k]);
        for (int j = 0; j < DB; j++) if (sout(n - j, k) == mf[k]) acc = 1'b0;
        if (acc) begin
          mf[k] = ~mf[k];
          last_ev[k] = n;
        end
        mo[k] = acc && (mf[k] ? mode[2*k] : mode[2*k+1]);
        ms[k] = (ms[k] && !clr[k]) || mo[k];
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < W; k++) if (o[k]) begin
      dut_p[k]++;
      dut_prev[k] = dut_pe[k];
      dut_pe[k] = n;
    end
    chk("model_o", o, mo);
    chk("model_sticky", sticky, ms);
    chk("model_level", level, mf);
  endtask
  initial begin
    for (int k = 0; k < W; k++) begin
      last_ev[k] = 0;
      dut_p[k] = 0;
      dut_pe[k] = 0;
      dut_prev[k] = 0;
    end
    tick();
    tick();
    chk("reset_o", o, '0);
    chk("reset_sticky", sticky, '0);
    chk("reset_level", level, {W{RL}});
    rst_n = 1'b1;
    mode = 8'b0000_0001;
    i[0] = 1'b1;
    repeat (4) tick();
    chk("lat_o_early", o, 4'b0000);
    chk("lat_level_early", level, 4'b0000);
    tick();
    chk("lat_o", o, 4'b0001);
    chk("lat_level", level, 4'b0001);
    chk("lat_sticky", sticky, 4'b0001);
    tick();
    chk("lat_o_drop", o, 4'b0000);
    mode = 8'b0000_1100;
    dut_p[1] = 0;
    i[1] = 1'b1;
    repeat (2) tick();
    i[1] = 1'b0;
    repeat (8) tick();
    chki("glitch_pulses", dut_p[1], 0);
    chkb("glitch_level", level[1], 1'b0);
    i[1] = 1'b1;
    repeat (3) tick();
    i[1] = 1'b0;
    repeat (10) tick();
    chki("pulse3_count", dut_p[1], 2);
    chki("pulse3_spacing", dut_pe[1] - dut_prev[1], 3);
    chkb("pulse3_level", level[1], 1'b0);
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = m[1:0];
      dut_p[2] = 0;
      i[2] = 1'b1;
      repeat (10) tick();
      chkb("mode_level_hi", level[2], 1'b1);
      i[2] = 1'b0;
      repeat (10) tick();
      chkb("mode_level_lo", level[2], 1'b0);
      chki("mode_pulses", dut_p[2], (m & 1) + (m >> 1));
    end
    mode[7:6] = 2'b01;
    i[3] = 1'b1;
    clr[3] = 1'b1;
    repeat (4) tick();
    chkb("coll_sticky_pre", sticky[3], 1'b0);
    tick();
    chkb("coll_o", o[3], 1'b1);
    chkb("coll_sticky", sticky[3], 1'b1);
    clr[3] = 1'b0;
    tick();
    chkb("coll_sticky_hold", sticky[3], 1'b1);
    clr[3] = 1'b1;
    tick();
    chkb("coll_sticky_clr", sticky[3], 1'b0);
    clr[3] = 1'b0;
    i = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 8'h55;
    i[0] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_o", o, 4'b0000);
    chk("rstmid_sticky", sticky, 4'b0000);
    chk("rstmid_level", level, 4'b0000);
    rst_n = 1'b1;
    repeat (4) tick();
    chkb("rstmid_o_early", o[0], 1'b0);
    tick();
    chkb("rstmid_o_late", o[0], 1'b1);
    i = '0;
    repeat (10) tick();
    chk("sim_level_lo", level, 4'b0000);
    i = 4'hF;
    repeat (4) tick();
    chk("sim_o_early", o, 4'b0000);
    tick();
    chk("sim_o", o, 4'b1111);
    chk("sim_sticky", sticky, 4'b1111);
    tick();
    chk("sim_o_drop", o, 4'b0000);
    for (int t = 0; t < 1500; t++) begin
      i = i ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if (t % 50 == 0) mode = 8'($urandom);
      clr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
